// File: rtl/bsc_axiu_burst_splitter_pkg.sv
// Shared definitions for the AXI burst splitter.
//   - AXI burst-type encodings (FIXED / INCR / WRAP)
//   - Default address width and interleave stride
//   - FSM state type for the splitter
package bsc_axiu_burst_splitter_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int          DEFAULT_ADDR_WIDTH = 64;
    localparam logic [63:0] DEFAULT_STRIDE     = 64'h400;

    // IDLE: nothing held, input accepted. EMIT: a sub-burst is being offered.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/bsc_axiu_split_calc.sv
// Combinational sub-burst calculator.
// Given a start address, beat size and the beats still to be issued, it
// returns how many beats fit before the next STRIDE boundary.
// Ports:
//   addr       in   start byte address of this sub-burst (may be unaligned)
//   size       in   log2 bytes per beat
//   remaining  in   beats still owed for the command (1..256)
//   beats      out  beats in this sub-burst
//   len        out  AXI len for this sub-burst (beats-1)
//   next_addr  out  start of the following sub-burst (a STRIDE boundary)
//   last       out  this sub-burst finishes the command
module bsc_axiu_split_calc
    import bsc_axiu_burst_splitter_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [63:0] STRIDE     = DEFAULT_STRIDE
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [8:0]            remaining,
    output logic [8:0]            beats,
    output logic [7:0]            len,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(STRIDE);

    logic [ADDR_WIDTH-1:0] size_mask;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] avail;
    logic [ADDR_WIDTH-1:0] rem_w;

    always_comb begin
        size_mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
        aligned   = addr & ~size_mask;
        offset    = aligned & (STRIDE_A - ADDR_WIDTH'(1));
        // Whole beats left before the next stride boundary.
        avail     = (STRIDE_A - offset) >> size;
        rem_w     = ADDR_WIDTH'(remaining);
        // avail is only narrowed when it is below remaining (<= 256).
        beats     = (rem_w < avail) ? remaining : avail[8:0];
        len       = 8'(beats - 9'd1);
        next_addr = aligned + (ADDR_WIDTH'(beats) << size);
        last      = (beats == remaining);
    end

endmodule

// File: rtl/bsc_axiu_burst_splitter.sv
// AXI address-channel burst splitter (one instance per AR or AW channel).
// Splits INCR bursts into sub-bursts that never cross a STRIDE boundary so
// each maps to a single interleaver bank. FIXED/WRAP pass through whole.
// Optional feature macro: BURST_SPLIT_STATS_EN adds saturating counters
// stat_cmds (accepted commands) and stat_subs (sub-burst handshakes).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      command handshake (in_ready high only in IDLE)
//   in_addr/len/size/burst/id  AXI command fields
//   out_valid / out_ready    sub-burst handshake
//   out_addr/len/size/burst/id sub-burst fields
//   out_split_last           high on the final sub-burst of a command
//   stat_cmds, stat_subs     counters (only with BURST_SPLIT_STATS_EN)
// Handshake: a transfer happens on a rising edge where valid && ready; the
// offering side holds valid and all payload stable until that edge.
module bsc_axiu_burst_splitter
    import bsc_axiu_burst_splitter_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int          ID_WIDTH   = 4,
    parameter logic [63:0] STRIDE     = DEFAULT_STRIDE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [7:0]            in_len,
    input  logic [2:0]            in_size,
    input  logic [1:0]            in_burst,
    input  logic [ID_WIDTH-1:0]   in_id,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [7:0]            out_len,
    output logic [2:0]            out_size,
    output logic [1:0]            out_burst,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic                  out_split_last
`ifdef BURST_SPLIT_STATS_EN
    ,
    output logic [31:0]           stat_cmds,
    output logic [31:0]           stat_subs
`endif
);

    state_t                state, state_d;
    logic [8:0]            remaining, rem_d;     // beats owed, including held sub-burst
    logic [8:0]            cur_beats, beats_d;   // beats in the held sub-burst
    logic [ADDR_WIDTH-1:0] next_addr_q, next_d;  // start of the following sub-burst
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [7:0]            len_d;
    logic [2:0]            size_d;
    logic [1:0]            burst_d;
    logic [ID_WIDTH-1:0]   id_d;
    logic                  last_d;

    logic [8:0]            in_beats;
    logic [8:0]            rem_after;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [2:0]            calc_size;
    logic [8:0]            calc_rem;
    logic [8:0]            calc_beats;
    logic [7:0]            calc_len;
    logic [ADDR_WIDTH-1:0] calc_next;
    logic                  calc_last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == EMIT);
    assign in_beats  = {1'b0, in_len} + 9'd1;
    assign rem_after = remaining - cur_beats;

    // One calculator serves both the first piece (from the input) and every
    // later piece (from the held next address and the post-handshake count).
    assign calc_addr = (state == IDLE) ? in_addr  : next_addr_q;
    assign calc_size = (state == IDLE) ? in_size  : out_size;
    assign calc_rem  = (state == IDLE) ? in_beats : rem_after;

    bsc_axiu_split_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STRIDE     (STRIDE)
    ) u_calc (
        .addr      (calc_addr),
        .size      (calc_size),
        .remaining (calc_rem),
        .beats     (calc_beats),
        .len       (calc_len),
        .next_addr (calc_next),
        .last      (calc_last)
    );

    always_comb begin
        state_d = state;
        addr_d  = out_addr;
        len_d   = out_len;
        size_d  = out_size;
        burst_d = out_burst;
        id_d    = out_id;
        last_d  = out_split_last;
        rem_d   = remaining;
        beats_d = cur_beats;
        next_d  = next_addr_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d = EMIT;
                    addr_d  = in_addr;
                    size_d  = in_size;
                    burst_d = in_burst;
                    id_d    = in_id;
                    rem_d   = in_beats;
                    if (in_burst == BURST_INCR) begin
                        len_d   = calc_len;
                        last_d  = calc_last;
                        beats_d = calc_beats;
                        next_d  = calc_next;
                    end else begin
                        // Whole command in one piece; rem_after becomes 0.
                        len_d   = in_len;
                        last_d  = 1'b1;
                        beats_d = in_beats;
                        next_d  = in_addr;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (rem_after == 9'd0) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                        rem_d   = 9'd0;
                        beats_d = 9'd0;
                    end else begin
                        addr_d  = next_addr_q;
                        len_d   = calc_len;
                        last_d  = calc_last;
                        beats_d = calc_beats;
                        next_d  = calc_next;
                        rem_d   = rem_after;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            out_addr       <= '0;
            out_len        <= '0;
            out_size       <= '0;
            out_burst      <= '0;
            out_id         <= '0;
            out_split_last <= 1'b0;
            remaining      <= '0;
            cur_beats      <= '0;
            next_addr_q    <= '0;
        end else begin
            state          <= state_d;
            out_addr       <= addr_d;
            out_len        <= len_d;
            out_size       <= size_d;
            out_burst      <= burst_d;
            out_id         <= id_d;
            out_split_last <= last_d;
            remaining      <= rem_d;
            cur_beats      <= beats_d;
            next_addr_q    <= next_d;
        end
    end

`ifdef BURST_SPLIT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cmds <= '0;
            stat_subs <= '0;
        end else begin
            if (in_valid && in_ready && (stat_cmds != 32'hFFFF_FFFF))
                stat_cmds <= stat_cmds + 32'd1;
            if (out_valid && out_ready && (stat_subs != 32'hFFFF_FFFF))
                stat_subs <= stat_subs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bsc_axiu_burst_splitter.sv
// Directed testbench for bsc_axiu_burst_splitter with a beat-level model:
// every burst is expanded into its individual beat addresses, which are then
// grouped by the STRIDE bank they fall in to form the expected sub-bursts.
module tb_bsc_axiu_burst_splitter;
  import bsc_axiu_burst_splitter_pkg::*;

  localparam int          AW     = 64;
  localparam int          IW     = 4;
  localparam logic [63:0] STRIDE = 64'h400;
  localparam int          SW     = AW + 8 + 3 + 2 + IW + 1;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [AW-1:0] in_addr;
  logic [7:0]    in_len;
  logic [2:0]    in_size;
  logic [1:0]    in_burst;
  logic [IW-1:0] in_id;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_len;
  logic [2:0]    out_size;
  logic [1:0]    out_burst;
  logic [IW-1:0] out_id;
  logic          out_split_last;
`ifdef BURST_SPLIT_STATS_EN
  logic [31:0]   stat_cmds, stat_subs;
`endif

  bsc_axiu_burst_splitter #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .STRIDE(STRIDE)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_len         (in_len),
    .in_size        (in_size),
    .in_burst       (in_burst),
    .in_id          (in_id),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_addr       (out_addr),
    .out_len        (out_len),
    .out_size       (out_size),
    .out_burst      (out_burst),
    .out_id         (out_id),
    .out_split_last (out_split_last)
`ifdef BURST_SPLIT_STATS_EN
    ,
    .stat_cmds      (stat_cmds),
    .stat_subs      (stat_subs)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int valid_seen = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] obs_q[$];
  logic [SW-1:0] mdl_q[$];
  int            obs_cyc_q[$];
  int            acc_cyc_q[$];
  logic [SW-1:0] cur, prev_out;
  logic          prev_stall = 1'b0;

  function automatic logic [SW-1:0] mk(logic [AW-1:0] a, logic [7:0] l, logic [2:0] s,
                                       logic [1:0] b, logic [IW-1:0] id, logic last);
    return {a, l, s, b, id, last};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_build(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input logic [IW-1:0] id);
    logic [AW-1:0] base, start, ba;
    logic [AW-1:0] bank, prev_bank;
    int cnt;
    mdl_q.delete();
    if (b != BURST_INCR) begin
      mdl_q.push_back(mk(a, l, s, b, id, 1'b1));
      return;
    end
    base      = a & ~((64'd1 << s) - 64'd1);
    start     = a;
    cnt       = 0;
    prev_bank = base / STRIDE;
    for (int i = 0; i <= int'(l); i++) begin
      ba   = base + (AW'(i) << s);
      bank = ba / STRIDE;
      if (bank != prev_bank) begin
        mdl_q.push_back(mk(start, 8'(cnt - 1), s, b, id, 1'b0));
        start     = ba;
        cnt       = 0;
        prev_bank = bank;
      end
      cnt++;
    end
    mdl_q.push_back(mk(start, 8'(cnt - 1), s, b, id, 1'b1));
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      cur = mk(out_addr, out_len, out_size, out_burst, out_id, out_split_last);
      if (prev_stall) chk("stall_stable", cur, prev_out);
      if (out_valid) valid_seen++;
      if (out_valid && out_ready) begin
        obs_q.push_back(cur);
        obs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_sub: got %h with nothing expected", cur);
        end else begin
          chk("sub", cur, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
      if (in_valid) begin
        assert ((64'd1 << in_size) <= STRIDE)
          else $error("in_size %0d exceeds stride", in_size);
      end
      if (in_valid && in_ready) begin
        acc_cyc_q.push_back(cyc);
        model_build(in_addr, in_len, in_size, in_burst, in_id);
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s,
                      input logic [1:0] b, input logic [IW-1:0] id);
    int n;
    in_addr  = a;
    in_len   = l;
    in_size  = s;
    in_burst = b;
    in_id    = id;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready never rose, waited %0d cycles", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (!(!out_valid && in_ready && exp_q.size() == 0) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  // ---------------- directed stimulus ----------------
  int vs;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_addr = '0; in_len = '0; in_size = '0; in_burst = '0; in_id = '0;
    out_ready = 1'b1;

    // Pin the model against hand-computed splits.
    model_build(64'h300, 8'd255, 3'd3, BURST_INCR, 4'd1);
    chk("model_t1_n", mdl_q.size(), 3);
    chk("model_t1_0", mdl_q[0], mk(64'h300, 8'd31, 3'd3, BURST_INCR, 4'd1, 1'b0));
    chk("model_t1_1", mdl_q[1], mk(64'h400, 8'd127, 3'd3, BURST_INCR, 4'd1, 1'b0));
    chk("model_t1_2", mdl_q[2], mk(64'h800, 8'd95, 3'd3, BURST_INCR, 4'd1, 1'b1));
    model_build(64'h3FC, 8'd1, 3'd3, BURST_INCR, 4'd2);
    chk("model_t2_n", mdl_q.size(), 2);
    chk("model_t2_1", mdl_q[1], mk(64'h400, 8'd0, 3'd3, BURST_INCR, 4'd2, 1'b1));

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_out_last", out_split_last, 0);
    chk("rst_out_id", out_id, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three-way split, back-to-back, first piece one cycle after acceptance.
    clear_obs();
    send(64'h300, 8'd255, 3'd3, BURST_INCR, 4'd1);
    wait_idle("t1");
    chk("t1_count", obs_q.size(), 3);
    chk("t1_sub0", obs_q[0], mk(64'h300, 8'd31, 3'd3, BURST_INCR, 4'd1, 1'b0));
    chk("t1_sub1", obs_q[1], mk(64'h400, 8'd127, 3'd3, BURST_INCR, 4'd1, 1'b0));
    chk("t1_sub2", obs_q[2], mk(64'h800, 8'd95, 3'd3, BURST_INCR, 4'd1, 1'b1));
    for (int k = 0; k < 3; k++) chk("t1_latency", obs_cyc_q[k] - acc_cyc_q[0], k + 1);

    // Unaligned start, one beat either side of the boundary.
    clear_obs();
    send(64'h3FC, 8'd1, 3'd3, BURST_INCR, 4'd2);
    wait_idle("t2");
    chk("t2_count", obs_q.size(), 2);
    chk("t2_sub0", obs_q[0], mk(64'h3FC, 8'd0, 3'd3, BURST_INCR, 4'd2, 1'b0));
    chk("t2_sub1", obs_q[1], mk(64'h400, 8'd0, 3'd3, BURST_INCR, 4'd2, 1'b1));

    // No crossing, two commands back to back: one accepted every 2 cycles.
    clear_obs();
    send(64'h000, 8'd15, 3'd2, BURST_INCR, 4'd3);
    send(64'h000, 8'd15, 3'd2, BURST_INCR, 4'd4);
    wait_idle("t3");
    chk("t3_count", obs_q.size(), 2);
    chk("t3_sub0", obs_q[0], mk(64'h000, 8'd15, 3'd2, BURST_INCR, 4'd3, 1'b1));
    chk("t3_interval", acc_cyc_q[1] - acc_cyc_q[0], 2);

    // FIXED and WRAP pass through whole even across a boundary.
    clear_obs();
    send(64'h3F0, 8'd15, 3'd2, BURST_FIXED, 4'd5);
    send(64'h3F0, 8'd3, 3'd2, BURST_WRAP, 4'd6);
    wait_idle("t4");
    chk("t4_count", obs_q.size(), 2);
    chk("t4_fixed", obs_q[0], mk(64'h3F0, 8'd15, 3'd2, BURST_FIXED, 4'd5, 1'b1));
    chk("t4_wrap", obs_q[1], mk(64'h3F0, 8'd3, 3'd2, BURST_WRAP, 4'd6, 1'b1));

    // Byte-sized beats crossing at the very last byte.
    clear_obs();
    send(64'h3FF, 8'd3, 3'd0, BURST_INCR, 4'd7);
    wait_idle("t5");
    chk("t5_count", obs_q.size(), 2);
    chk("t5_sub1", obs_q[1], mk(64'h400, 8'd2, 3'd0, BURST_INCR, 4'd7, 1'b1));

    // Backpressure for 5 cycles on the second piece.
    clear_obs();
    send(64'h300, 8'd255, 3'd3, BURST_INCR, 4'd8);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle("t6");
    chk("t6_count", obs_q.size(), 3);
    chk("t6_sub1", obs_q[1], mk(64'h400, 8'd127, 3'd3, BURST_INCR, 4'd8, 1'b0));
    chk("t6_sub2", obs_q[2], mk(64'h800, 8'd95, 3'd3, BURST_INCR, 4'd8, 1'b1));
    chk("t6_resume1", obs_cyc_q[1] - acc_cyc_q[0], 7);
    chk("t6_resume2", obs_cyc_q[2] - acc_cyc_q[0], 8);

    // Reset while the first of three pieces is held.
    clear_obs();
    send(64'h300, 8'd255, 3'd3, BURST_INCR, 4'd9);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("t7_out_valid", out_valid, 0);
    chk("t7_in_ready", in_ready, 1);
`ifdef BURST_SPLIT_STATS_EN
    chk("t7_stat_cmds", stat_cmds, 0);
    chk("t7_stat_subs", stat_subs, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    vs = valid_seen;
    repeat (10) @(posedge clk);
    #1;
    chk("t7_no_more_subs", valid_seen - vs, 0);
    chk("t7_obs_empty", obs_q.size(), 0);

`ifdef BURST_SPLIT_STATS_EN
    send(64'h300, 8'd255, 3'd3, BURST_INCR, 4'd1);
    wait_idle("t8");
    chk("t8_stat_cmds", stat_cmds, 1);
    chk("t8_stat_subs", stat_subs, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
